// File: rtl/frog_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frog_pkg : key indices and arbiter direction type for move_input    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package frog_pkg;

  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_LEFT  = 3;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_debounce : 2-flop synchroniser, debounce counter, press edge    |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Flip on the edge where the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= ~key_n_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_dly_q;

endmodule
`default_nettype wire

// File: rtl/move_input.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | move_input : debounced keys -> one-hot move pulses and pause level  |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module move_input
  import frog_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       pause_key_n,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       pause
);

  localparam int KEY_PAUSE = 4;

  logic [4:0] raw_n;
  logic [4:0] press;
  dir_e       dir;
  logic       up_q, down_q, left_q, right_q, pause_q;
  logic       up_d, down_d, left_d, right_d, pause_d;

  assign raw_n = {pause_key_n, key_n};

  generate
    for (genvar i = 0; i < 5; i++) begin : g_chan
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk    (clk),
        .reset  (reset),
        .key_n_i(raw_n[i]),
        .press_o(press[i])
      );
    end
  endgenerate

  // Moves are judged against the pause level before any toggle this cycle.
  always_comb begin
    dir = DIR_NONE;
    if (!pause_q) begin
      if (press[KEY_UP]) begin
        dir = DIR_UP;
      end else if (press[KEY_DOWN]) begin
        dir = DIR_DOWN;
      end else if (press[KEY_LEFT]) begin
        dir = DIR_LEFT;
      end else if (press[KEY_RIGHT]) begin
        dir = DIR_RIGHT;
      end
    end
  end

  always_comb begin
    up_d    = (dir == DIR_UP);
    down_d  = (dir == DIR_DOWN);
    left_d  = (dir == DIR_LEFT);
    right_d = (dir == DIR_RIGHT);
    pause_d = pause_q ^ press[KEY_PAUSE];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      up_q    <= up_d;
      down_q  <= down_d;
      left_q  <= left_d;
      right_q <= right_d;
      pause_q <= pause_d;
    end
  end

  assign up    = up_q;
  assign down  = down_q;
  assign left  = left_q;
  assign right = right_q;
  assign pause = pause_q;

endmodule
`default_nettype wire

// File: tb/tb_move_input.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_move_input : directed vector bench for move_input                |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_move_input;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       pause_key_n;
  logic       up, down, left, right, pause;

  int checks = 0;
  int errors = 0;
  int pc[4];      // pulse counts: 0=up 1=down 2=left 3=right
  int pt[4];      // step index of first pulse, -1 if none
  int stepno;

  typedef struct {
    logic [3:0] keys;
    int         win;   // expected winning direction index, -1 for none
    int         at;    // expected step of the pulse after the key change
  } vec_t;

  vec_t vecs[8];

  move_input #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .pause_key_n(pause_key_n),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .pause      (pause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_watch();
    stepno = 0;
    for (int d = 0; d < 4; d++) begin
      pc[d] = 0;
      pt[d] = -1;
    end
  endtask

  task automatic run(input int n);
    logic [3:0] o;
    for (int i = 0; i < n; i++) begin
      step();
      stepno++;
      o = {right, left, down, up};
      for (int d = 0; d < 4; d++) begin
        if (o[d]) begin
          pc[d]++;
          if (pt[d] < 0) pt[d] = stepno;
        end
      end
      chk("onehot", ($countones(o) <= 1) ? 1 : 0, 1);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    key_n       = 4'hF;
    pause_key_n = 1'b1;
    step();
    chk("rst_outs", int'({up, down, left, right, pause}), 0);
    step();
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{keys: 4'b1011, win: 0,  at: 7};
    vecs[1] = '{keys: 4'b1101, win: 1,  at: 7};
    vecs[2] = '{keys: 4'b0111, win: 2,  at: 7};
    vecs[3] = '{keys: 4'b1110, win: 3,  at: 7};
    vecs[4] = '{keys: 4'b1100, win: 1,  at: 7};
    vecs[5] = '{keys: 4'b0000, win: 0,  at: 7};
    vecs[6] = '{keys: 4'b0110, win: 2,  at: 7};
    vecs[7] = '{keys: 4'b1111, win: -1, at: -1};

    // Reset then idle
    do_reset();
    clear_watch();
    run(20);
    for (int d = 0; d < 4; d++) chk("idle_pulse", pc[d], 0);
    chk("idle_pause", int'(pause), 0);

    // Single and simultaneous presses, then release
    for (int v = 0; v < 8; v++) begin
      do_reset();
      run(3);
      clear_watch();
      key_n = vecs[v].keys;
      run(40);
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("vec%0d_cnt%0d", v, d), pc[d], (d == vecs[v].win) ? 1 : 0);
        if (d == vecs[v].win) chk($sformatf("vec%0d_time", v), pt[d], vecs[v].at);
      end
      key_n = 4'hF;
      clear_watch();
      run(20);
      for (int d = 0; d < 4; d++) chk($sformatf("vec%0d_rel%0d", v, d), pc[d], 0);
    end

    // Simultaneous right+down, release, then right alone
    do_reset();
    run(3);
    clear_watch();
    key_n = 4'b1100;
    run(20);
    chk("sim_down", pc[1], 1);
    chk("sim_right", pc[3], 0);
    key_n = 4'hF;
    run(20);
    clear_watch();
    key_n = 4'b1110;
    run(20);
    chk("solo_right", pc[3], 1);
    chk("solo_right_t", pt[3], 7);
    key_n = 4'hF;

    // Bounce on left: 2-cycle low/high for 12 cycles, then stable low
    do_reset();
    run(3);
    clear_watch();
    for (int b = 0; b < 3; b++) begin
      key_n = 4'b0111;
      run(2);
      key_n = 4'b1111;
      run(2);
    end
    run(6);
    chk("bounce_none", pc[2], 0);
    clear_watch();
    key_n = 4'b0111;
    run(20);
    chk("bounce_left", pc[2], 1);
    chk("bounce_left_t", pt[2], 7);
    key_n = 4'hF;

    // Pause toggling and move suppression
    do_reset();
    run(3);
    pause_key_n = 1'b0;
    run(6);
    chk("pause_pre", int'(pause), 0);
    run(1);
    chk("pause_on", int'(pause), 1);
    run(3);
    pause_key_n = 1'b1;
    run(15);
    chk("pause_hold", int'(pause), 1);
    clear_watch();
    key_n = 4'b1011;
    run(20);
    chk("paused_up", pc[0], 0);
    key_n = 4'hF;
    run(15);
    pause_key_n = 1'b0;
    run(20);
    pause_key_n = 1'b1;
    run(15);
    chk("pause_off", int'(pause), 0);
    clear_watch();
    key_n = 4'b1011;
    run(20);
    chk("unpaused_up", pc[0], 1);
    chk("unpaused_up_t", pt[0], 7);
    key_n = 4'hF;

    // Reset mid-debounce with down held throughout
    do_reset();
    run(3);
    clear_watch();
    key_n = 4'b1101;
    run(3);
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    chk("midrst_none", pc[1], 0);
    chk("midrst_outs", int'({up, down, left, right, pause}), 0);
    clear_watch();
    run(20);
    chk("midrst_down", pc[1], 1);
    chk("midrst_down_t", pt[1], 7);
    key_n = 4'hF;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/move_input.md
Name: move_input

Overview:
- Produces the movement command pulses (up, down, left, right) and the pause level consumed by the frog movement logic.
- Takes raw, asynchronous, bouncing push-button inputs (active-low board keys) and synchronises and debounces them.
- Each debounced press becomes exactly one single-cycle, mutually exclusive move pulse per clk cycle.
- Sits between the board keys and the frog movement block.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronised key level must differ from its debounced level before the debounced level flips. Legal range is 1 or more. Hardware build overrides to about 50000.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-low reset (reset=0 resets on the clk rising edge).
- key_n  input  4  raw buttons, active-low, asynchronous. Bit 0 = right, 1 = down, 2 = up, 3 = left.
- pause_key_n  input  1  raw pause button, active-low, asynchronous.
- up  output  1  one-cycle move-up pulse.
- down  output  1  one-cycle move-down pulse.
- left  output  1  one-cycle move-left pulse.
- right  output  1  one-cycle move-right pulse.
- pause  output  1  pause level; toggled by each debounced pause press.

Behaviour:
- Reset (reset=0 at an edge):
  - All synchroniser flops hold "released".
  - All debounced levels are "released".
  - All counters are 0.
  - up, down, left, right and pause are all 0.
- Synchroniser:
  - Each of the 5 raw inputs is inverted to active-high and passed through a 2-flop synchroniser.
  - sync2 is valid 2 edges after the raw input is sampled.
- Debounce, per key, 5 independent channels:
  - When sync2 equals the debounced level, the counter clears to 0.
  - When sync2 differs from the debounced level, the counter increments.
  - On the edge where the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: the debounced level goes from 0 to 1, detected against a 1-cycle delayed copy. Releases generate nothing.
- Latency: with a clean press sampled first at edge E, the debounced level flips at edge E+1+DEBOUNCE_CYCLES. The move pulse is high for exactly one cycle, beginning after edge E+2+DEBOUNCE_CYCLES. With the default, the pulse follows edge E+6.
- Arbitration: when several move press events occur in the same cycle, the priority is up > down > left > right.
  - Only the winner pulses.
  - Losers are dropped, not queued.
  - At most one of up/down/left/right is 1 in any cycle.
- No auto-repeat: holding a key yields one pulse. A new pulse requires release (debounced) followed by press (debounced).
- Pause:
  - A pause press event toggles the registered pause, with the same latency as a move pulse.
  - While pause=1, move press events are discarded. They are not held for later.
  - A move event in the same cycle as the pause toggle is evaluated against the old pause value.
- Keys held through reset: after reset deasserts, the debounced level starts at "released". A key still held therefore produces one press pulse after the normal debounce latency.
- Reset mid-debounce or mid-pulse: takes effect at the next edge, and all state returns to the reset values. An in-flight pulse is truncated and is not re-issued.

Decomposition:
- Package frog_pkg holds:
  - key index constants KEY_RIGHT=0, KEY_DOWN=1, KEY_UP=2, KEY_LEFT=3;
  - typedef enum dir_e {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}, used internally for the arbiter result.
- Sub-module key_debounce, parameterised by DEBOUNCE_CYCLES:
  - contents: 2-flop synchroniser, counter, debounced level, press-edge output;
  - instantiated 5 times.
- move_input owns the arbiter, the pause toggle and the output registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle: reset=0 for 2 cycles with key_n=4'b1111, then reset=1 -> all outputs 0 for 20 cycles.
- Clean press: key_n[2] falls and is held 10 cycles -> up=1 for exactly 1 cycle, after the 6th edge from the first sample. Holding for 30 more cycles gives no further pulse.
- Bounce: key_n[3] toggles low/high every 2 cycles for 12 cycles, then holds low -> no pulse during the bouncing. Exactly one left pulse follows, 6 edges after the final stable low is first sampled.
- Simultaneous: key_n[0] and key_n[1] fall on the same edge -> down pulses once, right never pulses. Release both, then press key_n[0] alone -> right pulses once.
- Pause: press and release pause_key_n -> pause=1. Press key_n[2] -> no up pulse. Press pause_key_n again -> pause=0. Press key_n[2] -> one up pulse.
- Reset mid-debounce: key_n[1] held low, reset=0 asserted 3 edges after the first sample, then reset=1 -> no pulse during reset. One down pulse follows 6 edges after the first post-reset sample.
